// File: rtl/cdb_multi_arbiter_if.sv
// Result-bus interface for the CDB arbiter: producer-side valid/ready handshakes
// and the NUM_BUS result buses fanned out to ROB, regfile and reservation stations.
interface cdb_multi_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int NUM_BUS = 1,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4
);
  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_value;
  logic [NUM_SRC-1:0]             src_upd_pc;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_upd_pc_val;

  logic [NUM_BUS-1:0]             bus_valid;
  logic [NUM_BUS-1:0][TAG_W-1:0]  bus_tag;
  logic [NUM_BUS-1:0][DATA_W-1:0] bus_value;
  logic [NUM_BUS-1:0]             bus_upd_pc;
  logic [NUM_BUS-1:0][DATA_W-1:0] bus_upd_pc_val;

  // The arbiter drives the buses and the ready lines.
  modport master (
    input  src_valid, src_tag, src_value, src_upd_pc, src_upd_pc_val,
    output src_ready,
    output bus_valid, bus_tag, bus_value, bus_upd_pc, bus_upd_pc_val
  );

  // Producers and bus consumers.
  modport slave (
    output src_valid, src_tag, src_value, src_upd_pc, src_upd_pc_val,
    input  src_ready,
    input  bus_valid, bus_tag, bus_value, bus_upd_pc, bus_upd_pc_val
  );
endinterface

// File: rtl/cdb_multi_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_BUS of NUM_SRC producers per cycle with
// urgent-first, round-robin (or fixed) priority, optional output register and flush.
module cdb_multi_arbiter #(
  parameter int                 NUM_SRC     = 4,
  parameter int                 NUM_BUS     = 1,
  parameter int                 DATA_W      = 16,
  parameter int                 TAG_W       = 4,
  parameter bit                 RR_MODE     = 1'b1,
  parameter logic [NUM_SRC-1:0] URGENT_MASK = NUM_SRC'(1),
  parameter bit                 REG_OUT     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  cdb_multi_arbiter_if.master cdb,
  output logic [15:0]         conflict_cnt
);
  localparam int PTR_W = $clog2(NUM_SRC);
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t               rr_ptr;
  ptr_t               rr_ptr_nxt;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_BUS-1:0] sel_valid;
  ptr_t               sel [NUM_BUS];
  logic               nu_hit;
  ptr_t               nu_last;
  logic               conflict;

  logic [NUM_BUS-1:0][TAG_W-1:0]  mux_tag;
  logic [NUM_BUS-1:0][DATA_W-1:0] mux_value;
  logic [NUM_BUS-1:0]             mux_upd_pc;
  logic [NUM_BUS-1:0][DATA_W-1:0] mux_upd_pc_val;

  function automatic ptr_t wrap_idx(input ptr_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return ptr_t'(s);
  endfunction

  // Two passes (urgent class, then the rest), each scanning from the same start
  // point; the k-th grant found is steered onto bus k.
  always_comb begin
    int   nb;
    ptr_t start;
    ptr_t idx;
    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    grant     = '0;
    sel_valid = '0;
    nu_hit    = 1'b0;
    nu_last   = '0;
    for (int k = 0; k < NUM_BUS; k++) sel[k] = '0;
    nb    = 0;
    idx   = '0;
    start = RR_MODE ? rr_ptr : '0;
    if (!rst && !flush) begin
      for (int cls = 0; cls < 2; cls++) begin
        for (int j = 0; j < NUM_SRC; j++) begin
          idx = wrap_idx(start, j);
          if (cdb.src_valid[idx] && (URGENT_MASK[idx] == (cls == 0)) && nb < NUM_BUS) begin
            grant[idx] = 1'b1;
            for (int k = 0; k < NUM_BUS; k++) begin
              if (nb == k) begin
                sel[k]       = idx;
                sel_valid[k] = 1'b1;
              end
            end
            nb = nb + 1;
            if (cls == 1) begin
              nu_hit  = 1'b1;
              nu_last = idx;
            end
          end
        end
      end
    end
  end

  assign cdb.src_ready = grant;
  assign conflict      = !flush && |(cdb.src_valid & ~grant);

  // Pointer moves past the last non-urgent winner so urgent traffic cannot
  // disturb fairness among the remaining sources.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (RR_MODE && nu_hit) rr_ptr_nxt = wrap_idx(nu_last, 1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_BUS; k++) begin
      mux_tag[k]        = '0;
      mux_value[k]      = '0;
      mux_upd_pc[k]     = 1'b0;
      mux_upd_pc_val[k] = '0;
      if (sel_valid[k]) begin
        mux_tag[k]        = cdb.src_tag[sel[k]];
        mux_value[k]      = cdb.src_value[sel[k]];
        mux_upd_pc[k]     = cdb.src_upd_pc[sel[k]];
        mux_upd_pc_val[k] = cdb.src_upd_pc_val[sel[k]];
      end
    end
  end

  if (REG_OUT) begin : g_reg_out
    // Grants are already suppressed during flush, so the bus goes idle the
    // cycle after it; idle buses keep their last payload.
    always_ff @(posedge clk) begin
      if (rst) begin
        cdb.bus_valid      <= '0;
        cdb.bus_tag        <= '0;
        cdb.bus_value      <= '0;
        cdb.bus_upd_pc     <= '0;
        cdb.bus_upd_pc_val <= '0;
      end else begin
        cdb.bus_valid <= sel_valid;
        for (int k = 0; k < NUM_BUS; k++) begin
          if (sel_valid[k]) begin
            cdb.bus_tag[k]        <= mux_tag[k];
            cdb.bus_value[k]      <= mux_value[k];
            cdb.bus_upd_pc[k]     <= mux_upd_pc[k];
            cdb.bus_upd_pc_val[k] <= mux_upd_pc_val[k];
          end
        end
      end
    end
  end else begin : g_comb_out
    always_comb begin
      cdb.bus_valid      = sel_valid;
      cdb.bus_tag        = mux_tag;
      cdb.bus_value      = mux_value;
      cdb.bus_upd_pc     = mux_upd_pc;
      cdb.bus_upd_pc_val = mux_upd_pc_val;
    end
  end
endmodule

// File: tb/tb_cdb_multi_arbiter.sv
// Scoreboard bench for cdb_multi_arbiter: four configurations share clock/reset/flush;
// expected bus records are queued at grant time and popped when a bus goes valid.
module tb_cdb_multi_arbiter;
  localparam int ND = 4;
  localparam int NS = 4;

  typedef struct packed {
    logic        bus;
    logic [3:0]  tag;
    logic [15:0] val;
    logic        upc;
    logic [15:0] upv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  logic [NS-1:0]        sv   [ND];
  logic [NS-1:0][3:0]   stag [ND];
  logic [NS-1:0][15:0]  sval [ND];
  logic [NS-1:0]        supc [ND];
  logic [NS-1:0][15:0]  supv [ND];
  logic [NS-1:0]        rdy  [ND];
  logic [1:0]           bv   [ND];
  logic [1:0][3:0]      btag [ND];
  logic [1:0][15:0]     bval [ND];
  logic [1:0]           bupc [ND];
  logic [1:0][15:0]     bupv [ND];
  logic [15:0]          cc   [ND];
  logic [15:0]          cc0, cc1, cc2, cc3;

  exp_t       sbq      [ND][$];
  bit         pend     [ND][NS];
  int         seq      [ND][NS];
  logic [3:0] last_tag [ND];
  int         n_total = 0;
  int         n_bad   = 0;

  cdb_multi_arbiter_if #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(16), .TAG_W(4)) if_rr   ();
  cdb_multi_arbiter_if #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(16), .TAG_W(4)) if_urg  ();
  cdb_multi_arbiter_if #(.NUM_SRC(4), .NUM_BUS(2), .DATA_W(16), .TAG_W(4)) if_dual ();
  cdb_multi_arbiter_if #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(16), .TAG_W(4)) if_cmb  ();

  cdb_multi_arbiter #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(16), .TAG_W(4), .RR_MODE(1'b1),
                      .URGENT_MASK(4'b0000), .REG_OUT(1'b1))
    u_rr (.clk(clk), .rst(rst), .flush(flush), .cdb(if_rr.master), .conflict_cnt(cc0));
  cdb_multi_arbiter #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(16), .TAG_W(4), .RR_MODE(1'b1),
                      .URGENT_MASK(4'b0001), .REG_OUT(1'b1))
    u_urg (.clk(clk), .rst(rst), .flush(flush), .cdb(if_urg.master), .conflict_cnt(cc1));
  cdb_multi_arbiter #(.NUM_SRC(4), .NUM_BUS(2), .DATA_W(16), .TAG_W(4), .RR_MODE(1'b1),
                      .URGENT_MASK(4'b0000), .REG_OUT(1'b1))
    u_dual (.clk(clk), .rst(rst), .flush(flush), .cdb(if_dual.master), .conflict_cnt(cc2));
  cdb_multi_arbiter #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(16), .TAG_W(4), .RR_MODE(1'b0),
                      .URGENT_MASK(4'b0000), .REG_OUT(1'b0))
    u_cmb (.clk(clk), .rst(rst), .flush(flush), .cdb(if_cmb.master), .conflict_cnt(cc3));

  assign if_rr.src_valid        = sv[0];
  assign if_rr.src_tag          = stag[0];
  assign if_rr.src_value        = sval[0];
  assign if_rr.src_upd_pc       = supc[0];
  assign if_rr.src_upd_pc_val   = supv[0];
  assign if_urg.src_valid       = sv[1];
  assign if_urg.src_tag         = stag[1];
  assign if_urg.src_value       = sval[1];
  assign if_urg.src_upd_pc      = supc[1];
  assign if_urg.src_upd_pc_val  = supv[1];
  assign if_dual.src_valid      = sv[2];
  assign if_dual.src_tag        = stag[2];
  assign if_dual.src_value      = sval[2];
  assign if_dual.src_upd_pc     = supc[2];
  assign if_dual.src_upd_pc_val = supv[2];
  assign if_cmb.src_valid       = sv[3];
  assign if_cmb.src_tag         = stag[3];
  assign if_cmb.src_value       = sval[3];
  assign if_cmb.src_upd_pc      = supc[3];
  assign if_cmb.src_upd_pc_val  = supv[3];

  assign rdy[0]  = if_rr.src_ready;
  assign rdy[1]  = if_urg.src_ready;
  assign rdy[2]  = if_dual.src_ready;
  assign rdy[3]  = if_cmb.src_ready;
  assign bv[0]   = {1'b0, if_rr.bus_valid};
  assign bv[1]   = {1'b0, if_urg.bus_valid};
  assign bv[2]   = if_dual.bus_valid;
  assign bv[3]   = {1'b0, if_cmb.bus_valid};
  assign btag[0] = {4'h0, if_rr.bus_tag};
  assign btag[1] = {4'h0, if_urg.bus_tag};
  assign btag[2] = if_dual.bus_tag;
  assign btag[3] = {4'h0, if_cmb.bus_tag};
  assign bval[0] = {16'h0, if_rr.bus_value};
  assign bval[1] = {16'h0, if_urg.bus_value};
  assign bval[2] = if_dual.bus_value;
  assign bval[3] = {16'h0, if_cmb.bus_value};
  assign bupc[0] = {1'b0, if_rr.bus_upd_pc};
  assign bupc[1] = {1'b0, if_urg.bus_upd_pc};
  assign bupc[2] = if_dual.bus_upd_pc;
  assign bupc[3] = {1'b0, if_cmb.bus_upd_pc};
  assign bupv[0] = {16'h0, if_rr.bus_upd_pc_val};
  assign bupv[1] = {16'h0, if_urg.bus_upd_pc_val};
  assign bupv[2] = if_dual.bus_upd_pc_val;
  assign bupv[3] = {16'h0, if_cmb.bus_upd_pc_val};
  assign cc[0]   = cc0;
  assign cc[1]   = cc1;
  assign cc[2]   = cc2;
  assign cc[3]   = cc3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Payload of source s of configuration d for its seq-th result.
  task automatic gen(input int d, input int s);
    logic [7:0] n;
    n = 8'(seq[d][s]);
    stag[d][s] = 4'(s + 4 * seq[d][s]);
    sval[d][s] = {4'(d), 4'(s), n};
    supc[d][s] = n[0] ^ 1'(s);
    supv[d][s] = {n, 4'(s), 4'(d)} ^ 16'h5A5A;
  endtask

  task automatic push(input int d, input int k, input int s);
    exp_t e;
    e.bus = 1'(k);
    e.tag = stag[d][s];
    e.val = sval[d][s];
    e.upc = supc[d][s];
    e.upv = supv[d][s];
    sbq[d].push_back(e);
    last_tag[d] = stag[d][s];
    pend[d][s]  = 1'b1;
  endtask

  // One cycle on configuration d: drive valids and flush, check the ready vector
  // against the expected grants (e0 -> bus 0, e1 -> bus 1, -1 = none), queue results.
  task automatic step(input int d, input logic [3:0] v, input int e0, input int e1,
                      input logic f);
    logic [3:0] g;
    @(negedge clk);
    for (int dd = 0; dd < ND; dd++) begin
      for (int s = 0; s < NS; s++) begin
        if (pend[dd][s]) begin
          pend[dd][s] = 1'b0;
          seq[dd][s]++;
          gen(dd, s);
        end
      end
    end
    flush = f;
    sv[d] = v;
    #2;
    g = '0;
    if (e0 >= 0) g[e0] = 1'b1;
    if (e1 >= 0) g[e1] = 1'b1;
    check($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(g));
    if (e0 >= 0) push(d, 0, e0);
    if (e1 >= 0) push(d, 1, e1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      for (int d = 0; d < ND; d++) begin
        for (int k = 0; k < 2; k++) begin
          if (bv[d][k] === 1'b1) begin
            if (sbq[d].size() == 0) begin
              check($sformatf("d%0d_bus%0d_unexpected_valid", d, k), 32'(bv[d][k]), 32'd0);
            end else begin
              e = sbq[d].pop_front();
              check($sformatf("d%0d_bus_index", d), k, 32'(e.bus));
              check($sformatf("d%0d_bus%0d_tag", d, k), 32'(btag[d][k]), 32'(e.tag));
              check($sformatf("d%0d_bus%0d_value", d, k), 32'(bval[d][k]), 32'(e.val));
              check($sformatf("d%0d_bus%0d_upd_pc", d, k), 32'(bupc[d][k]), 32'(e.upc));
              check($sformatf("d%0d_bus%0d_upd_pc_val", d, k), 32'(bupv[d][k]), 32'(e.upv));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (bad so far=%0d)", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst   = 1'b1;
    flush = 1'b0;
    for (int d = 0; d < ND; d++) begin
      sv[d]       = '0;
      last_tag[d] = '0;
      for (int s = 0; s < NS; s++) begin
        seq[d][s]  = 0;
        pend[d][s] = 1'b0;
        gen(d, s);
      end
    end

    // Reset with every source requesting: no grants, everything cleared.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) sv[d] = 4'hF;
      #2;
      for (int d = 0; d < ND; d++) begin
        check($sformatf("d%0d_rst_ready", d), 32'(rdy[d]), 32'd0);
        check($sformatf("d%0d_rst_bus_valid", d), 32'(bv[d]), 32'd0);
        check($sformatf("d%0d_rst_conflict", d), 32'(cc[d]), 32'd0);
        check($sformatf("d%0d_rst_bus_tag", d), 32'(btag[d]), 32'd0);
        check($sformatf("d%0d_rst_bus_value", d), bval[d], 32'd0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) sv[d] = '0;
    #2;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_post_rst_bus_valid", d), 32'(bv[d]), 32'd0);
      check($sformatf("d%0d_post_rst_conflict", d), 32'(cc[d]), 32'd0);
    end

    // Round robin, one bus, all four requesting.
    for (int i = 0; i < 5; i++) begin
      step(0, 4'hF, i % 4, -1, 1'b0);
      check("rr_conflict_cnt", 32'(cc[0]), i);
      if (i == 0) check("rr_registered_latency", 32'(bv[0]), 32'd0);
    end
    step(0, 4'h0, -1, -1, 1'b0);
    check("rr_conflict_total", 32'(cc[0]), 32'd5);
    step(0, 4'h0, -1, -1, 1'b0);
    check("rr_idle_bus_valid", 32'(bv[0]), 32'd0);
    check("rr_idle_payload_held", 32'(btag[0][0]), 32'(last_tag[0]));

    // Flush right after a transfer on src1; src2 waits and wins first after it.
    stag[0][1] = 4'h5;
    step(0, 4'b0110, 1, -1, 1'b0);
    step(0, 4'b0100, -1, -1, 1'b1);
    step(0, 4'b0100, 2, -1, 1'b0);
    check("flush_next_bus_valid", 32'(bv[0]), 32'd0);
    step(0, 4'h0, -1, -1, 1'b0);
    check("flush_conflict_cnt", 32'(cc[0]), 32'd6);
    step(0, 4'h0, -1, -1, 1'b0);

    // Urgent src0 starves src2 until it drops.
    for (int i = 0; i < 3; i++) step(1, 4'b0101, 0, -1, 1'b0);
    step(1, 4'b0100, 2, -1, 1'b0);
    step(1, 4'h0, -1, -1, 1'b0);
    check("urgent_conflict_cnt", 32'(cc[1]), 32'd3);

    // Two buses: scan order decides bus assignment, including wrap-around.
    step(2, 4'b1011, 0, 1, 1'b0);
    step(2, 4'b1000, 3, -1, 1'b0);
    step(2, 4'b1111, 0, 1, 1'b0);
    step(2, 4'b1111, 2, 3, 1'b0);
    step(2, 4'b0100, 2, -1, 1'b0);
    step(2, 4'b1011, 3, 0, 1'b0);
    step(2, 4'b0010, 1, -1, 1'b0);
    step(2, 4'h0, -1, -1, 1'b0);
    step(2, 4'h0, -1, -1, 1'b0);

    // Fixed priority with combinational outputs.
    step(3, 4'b1010, 1, -1, 1'b0);
    check("comb_same_cycle_valid", 32'(bv[3]), 32'd1);
    check("comb_same_cycle_tag", 32'(btag[3][0]), 32'(last_tag[3]));
    step(3, 4'b1000, 3, -1, 1'b0);
    step(3, 4'b1110, 1, -1, 1'b0);
    step(3, 4'b1110, 1, -1, 1'b0);
    step(3, 4'b1100, 2, -1, 1'b0);
    step(3, 4'b1000, 3, -1, 1'b0);
    step(3, 4'h0, -1, -1, 1'b0);
    check("comb_idle_bus_valid", 32'(bv[3]), 32'd0);
    check("comb_idle_tag_zero", 32'(btag[3][0]), 32'd0);
    check("comb_idle_value_zero", 32'(bval[3][0]), 32'd0);

    // Saturation of the conflict counter (starts from 3 on this configuration).
    for (int i = 0; i < 65532; i++) step(1, 4'b0101, 0, -1, 1'b0);
    check("sat_before", 32'(cc[1]), 32'h0000_FFFE);
    step(1, 4'b0101, 0, -1, 1'b0);
    check("sat_reached", 32'(cc[1]), 32'h0000_FFFF);
    for (int i = 0; i < 4; i++) step(1, 4'b0101, 0, -1, 1'b0);
    check("sat_held", 32'(cc[1]), 32'h0000_FFFF);
    step(1, 4'h0, -1, -1, 1'b0);
    step(1, 4'h0, -1, -1, 1'b0);

    for (int d = 0; d < ND; d++)
      check($sformatf("d%0d_scoreboard_drained", d), sbq[d].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
